// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: {pc, inst} FIFO between the IF and ID stages.
// IF pushes with enq_valid_i/enq_ready_o and ID pops with deq_valid_o/deq_ready_i.
// flush_i empties the queue in one cycle when a branch or exception redirects fetch.
// enq_ready_o depends only on registered occupancy, so ID back-pressure never
// reaches IF combinationally. A full queue refuses a push even in a cycle where it pops.
// There is no enqueue-to-dequeue bypass. A new entry reaches the head one cycle later.
// Optional feature: define RISCV_FETCH_QUEUE_STATS_EN to add two counters.
// stat_stall_o counts cycles where IF is blocked by a full queue.
// stat_flush_o counts flush cycles.
module riscv_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  input  logic [XLEN-1:0]        enq_pc_i,
  input  logic [XLEN-1:0]        enq_inst_i,
  output logic                   enq_ready_o,
  output logic                   deq_valid_o,
  output logic [XLEN-1:0]        deq_pc_o,
  output logic [XLEN-1:0]        deq_inst_o,
  input  logic                   deq_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o
`ifdef RISCV_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_stall_o,
  output logic [15:0]            stat_flush_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [XLEN-1:0]  mem_inst [DEPTH];
  logic             enq_fire;
  logic             deq_fire;

  assign enq_ready_o   = (count != CNT_W'(DEPTH));
  assign deq_valid_o   = (count != '0);
  assign count_o       = count;
  assign almost_full_o = (count >= CNT_W'(DEPTH - 1));
  assign deq_pc_o      = mem_pc[rd_ptr];
  assign deq_inst_o    = mem_inst[rd_ptr];

  // A flush cycle suppresses both handshakes.
  assign enq_fire = enq_valid_i & enq_ready_o & ~flush_i;
  assign deq_fire = deq_valid_o & deq_ready_i & ~flush_i;

  // Pointers and occupancy. A flush returns everything to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. It has no reset because only occupied slots are ever read as valid.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_pc[wr_ptr]   <= enq_pc_i;
      mem_inst[wr_ptr] <= enq_inst_i;
    end
  end

`ifdef RISCV_FETCH_QUEUE_STATS_EN
  // Saturating stall and flush counters. flush_i does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_o <= '0;
      stat_flush_o <= '0;
    end else begin
      if (enq_valid_i && !enq_ready_o && (stat_stall_o != '1))
        stat_stall_o <= stat_stall_o + 32'd1;
      if (flush_i && (stat_flush_o != '1))
        stat_flush_o <= stat_flush_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: scoreboard bench for riscv_fetch_queue.
// The driver applies directed and random stimulus after each rising edge.
// The monitor samples on the falling edge. It compares flags, occupancy and the
// head entry against a queue model, then updates the model for that cycle.
module tb_riscv_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ent_t;

  logic            clk;
  logic            rst_n;
  logic            flush_i;
  logic            enq_valid_i;
  logic [XLEN-1:0] enq_pc_i;
  logic [XLEN-1:0] enq_inst_i;
  logic            enq_ready_o;
  logic            deq_valid_o;
  logic [XLEN-1:0] deq_pc_o;
  logic [XLEN-1:0] deq_inst_o;
  logic            deq_ready_i;
  logic [2:0]      count_o;
  logic            almost_full_o;
`ifdef RISCV_FETCH_QUEUE_STATS_EN
  logic [31:0]     stat_stall_o;
  logic [15:0]     stat_flush_o;
`endif

  int   errors = 0;
  int   checks = 0;
  ent_t exp_q[$];
  int   occ_s;
`ifdef RISCV_FETCH_QUEUE_STATS_EN
  logic [31:0] m_stall;
  logic [15:0] m_flush;
`endif

  riscv_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .enq_valid_i  (enq_valid_i),
    .enq_pc_i     (enq_pc_i),
    .enq_inst_i   (enq_inst_i),
    .enq_ready_o  (enq_ready_o),
    .deq_valid_o  (deq_valid_o),
    .deq_pc_o     (deq_pc_o),
    .deq_inst_o   (deq_inst_o),
    .deq_ready_i  (deq_ready_i),
    .count_o      (count_o),
    .almost_full_o(almost_full_o)
`ifdef RISCV_FETCH_QUEUE_STATS_EN
    ,
    .stat_stall_o (stat_stall_o),
    .stat_flush_o (stat_flush_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard. This is the only process that touches the model queue.
  initial begin
    occ_s = 0;
`ifdef RISCV_FETCH_QUEUE_STATS_EN
    m_stall = '0;
    m_flush = '0;
`endif
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        exp_q.delete();
        occ_s = 0;
`ifdef RISCV_FETCH_QUEUE_STATS_EN
        m_stall = '0;
        m_flush = '0;
        chk("rst_stat_stall", 64'(stat_stall_o), 64'd0);
`endif
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid_o), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready_o), 64'd1);
        chk("rst_almost_full", 64'(almost_full_o), 64'd0);
      end else begin
        occ_s = exp_q.size();
        chk("count", 64'(count_o), 64'(occ_s));
        chk("enq_ready", 64'(enq_ready_o), 64'(occ_s != DEPTH));
        chk("deq_valid", 64'(deq_valid_o), 64'(occ_s != 0));
        chk("almost_full", 64'(almost_full_o), 64'(occ_s >= DEPTH - 1));
`ifdef RISCV_FETCH_QUEUE_STATS_EN
        chk("stat_stall", 64'(stat_stall_o), 64'(m_stall));
        chk("stat_flush", 64'(stat_flush_o), 64'(m_flush));
        if (enq_valid_i && occ_s == DEPTH && m_stall != '1) m_stall = m_stall + 1;
        if (flush_i && m_flush != '1) m_flush = m_flush + 1;
`endif
        if (occ_s != 0) begin
          chk("head_pc", 64'(deq_pc_o), 64'(exp_q[0].pc));
          chk("head_inst", 64'(deq_inst_o), 64'(exp_q[0].inst));
          if (deq_ready_i && !flush_i) void'(exp_q.pop_front());
        end
        if (flush_i) exp_q.delete();
        else if (enq_valid_i && occ_s != DEPTH) exp_q.push_back('{pc: enq_pc_i, inst: enq_inst_i});
      end
    end
  end

  task automatic cyc(input logic ev, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                     input logic dr, input logic fl);
    @(posedge clk);
    #1;
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_inst_i  = inst;
    deq_ready_i = dr;
    flush_i     = fl;
  endtask

  // Driver: directed scenarios followed by a randomized soak.
  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    enq_valid_i = 1'b0;
    enq_pc_i = '0;
    enq_inst_i = '0;
    deq_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single entry, then drain it
    cyc(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // fill to full, then push while full, then push and pop together while full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(4 * i), $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 32'hdead_0010, 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 32'hdead_0010, 1'b1, 1'b0);
    cyc(1'b1, 32'h10, 32'hdead_0010, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // streaming: count holds at 1 while both pointers wrap twice
    cyc(1'b1, 32'h0, $urandom, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) cyc(1'b1, 32'(4 * i), $urandom, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // flush with three entries while enq and deq are both requested
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h200 + 4 * i), $urandom, 1'b0, 1'b0);
    cyc(1'b1, 32'h2f0, 32'hbad0_0001, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // full-stall cycles, then async reset mid-stream with two entries
    for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, 32'(32'h300 + 4 * i), $urandom, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h400, 32'h1111_1111, 1'b0, 1'b0);
    cyc(1'b1, 32'h404, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    enq_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // randomized soak with changing back-pressure levels
    for (int i = 0; i < 3000; i++) begin
      int band;
      band = (i / 300) % 3;
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
          (band == 0) ? ($urandom_range(0, 3) == 0) :
          (band == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 39) == 0);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #7;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
